// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter
//   Shares one byte-addressed memory between instruction fetch (32-bit reads)
//   and the data path (64-bit loads/stores). One transaction at a time,
//   data has priority, and fetch starvation is bounded by starve_cnt.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   if_req/if_addr    : fetch request (held until if_done)
//   if_done/if_rdata  : fetch completion pulse and instruction word
//   d_req/d_we/d_addr/d_wdata : data request (held until d_done)
//   d_done/d_rdata    : data completion pulse and load data
//   m_en/m_we/m_addr/m_wdata  : memory access, one m_en cycle per transaction
//   m_rdata           : memory read data, valid LAT cycles after m_en
//   busy              : transaction in flight (ISSUE..DONE)
//   owner             : current grant, 0 fetch / 1 data
module tinker_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LAT          = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_done,
  output logic [63:0]       d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [63:0]       m_wdata,
  input  logic [63:0]       m_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic [LW-1:0]   lat_cnt;
  logic            is_store;
  logic            grant_d;

  // Data wins a tie unless fetch has already waited through STARVE_LIMIT
  // consecutive data grants.
  assign grant_d = d_req && !(if_req && (starve_cnt == SW'(STARVE_LIMIT)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      is_store   <= 1'b0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state <= ISSUE;
            busy  <= 1'b1;
            m_en  <= 1'b1;
            owner <= grant_d;
            if (grant_d) begin
              m_addr   <= d_addr;
              m_we     <= d_we;
              m_wdata  <= d_wdata;
              is_store <= d_we;
              // Count only grants that actually made fetch wait.
              if (!if_req)
                starve_cnt <= '0;
              else if (starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);
            end else begin
              m_addr     <= if_addr;
              m_we       <= 1'b0;
              is_store   <= 1'b0;
              starve_cnt <= '0;
            end
          end
        end
        ISSUE: begin
          m_en <= 1'b0;
          m_we <= 1'b0;
          if (is_store) begin
            d_done <= 1'b1;
            state  <= DONE;
          end else begin
            // Counts the remaining WAIT cycles before m_rdata is valid.
            lat_cnt <= LW'(LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            if (owner) begin
              d_rdata <= m_rdata;
              d_done  <= 1'b1;
            end else begin
              if_rdata <= m_rdata[31:0];
              if_done  <= 1'b1;
            end
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        DONE: begin
          // Requests present now are not arbitrated; next look is in IDLE.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Bench for tinker_mem_arbiter: directed scenarios followed by random
// request rounds, checked against a transaction-level reference model
// (reference memory + starvation counter computed from the arbitration rules).
module tb_tinker_mem_arbiter;
  localparam int LAT = 2;
  localparam int SL  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr;
  logic [63:0] d_wdata;
  logic        if_done, d_done, m_en, m_we, busy, owner;
  logic [31:0] if_rdata, m_addr;
  logic [63:0] d_rdata, m_wdata, m_rdata;

  tinker_mem_arbiter #(.ADDR_W(32), .LAT(LAT), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Memory array driven by the DUT's m_* port; reads return after LAT cycles,
  // other cycles carry junk so a mistimed capture shows up.
  logic [63:0] mem     [logic [31:0]];
  logic [63:0] ref_mem [logic [31:0]];
  logic [63:0] rd_pipe [LAT];
  assign m_rdata = rd_pipe[LAT-1];

  function automatic logic [63:0] dflt(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction
  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [63:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] = m_wdata;
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (m_en && !m_we) ? mem_rd(m_addr) : {$urandom, $urandom};
  end

  int checks = 0;
  int errors = 0;
  int starve = 0;
  bit          f_pend, d_pend, d_we_v;
  logic [31:0] f_addr, d_addr_v;
  logic [63:0] d_wd;
  logic [31:0] exp_if;
  logic [63:0] exp_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if_req  = f_pend;
    if_addr = f_addr;
    d_req   = d_pend;
    d_we    = d_we_v;
    d_addr  = d_addr_v;
    d_wdata = d_wd;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m_en"}, m_en, 0);     chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_if_done"}, if_done, 0); chk({tag, "_d_done"}, d_done, 0);
    chk({tag, "_busy"}, busy, 0);     chk({tag, "_owner"}, owner, 0);
    chk({tag, "_m_addr"}, m_addr, 0); chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0); chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  task automatic new_fetch();
    f_pend = 1'b1;
    f_addr = 32'h1000 + 32'($urandom_range(0, 31) << 2);
  endtask
  task automatic new_data();
    d_pend   = 1'b1;
    d_we_v   = 1'($urandom_range(0, 1));
    d_addr_v = 32'h1000 + 32'($urandom_range(0, 15) << 3);
    d_wd     = {$urandom, $urandom};
  endtask

  // One arbitration round: inputs are presented in an IDLE cycle; the
  // granted request is serviced and dropped, the other stays held.
  task automatic round();
    bit          gd;
    int          n;
    int          lat;
    logic [63:0] v;
    drive();
    gd = d_pend && !(f_pend && starve == SL);
    if (gd) starve = f_pend ? ((starve < SL) ? starve + 1 : SL) : 0;
    else    starve = 0;
    @(posedge clk); #1;
    chk("issue_m_en", m_en, 1);
    chk("issue_owner", owner, gd);
    chk("issue_busy", busy, 1);
    chk("issue_m_addr", m_addr, gd ? d_addr_v : f_addr);
    chk("issue_m_we", m_we, gd && d_we_v);
    if (gd && d_we_v) chk("issue_m_wdata", m_wdata, d_wd);
    lat = (gd && d_we_v) ? 1 : LAT + 1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(if_done || d_done) && n < 12);
    chk("done_latency", n, lat);
    chk("done_if", if_done, !gd);
    chk("done_d", d_done, gd);
    chk("done_busy", busy, 1);
    chk("done_m_en", m_en, 0);
    if (gd) begin
      if (d_we_v) ref_mem[d_addr_v] = d_wd;
      else        exp_d = ref_rd(d_addr_v);
      d_pend = 1'b0;
    end else begin
      v = ref_rd(f_addr);
      exp_if = v[31:0];
      f_pend = 1'b0;
    end
    chk("if_rdata", if_rdata, exp_if);
    chk("d_rdata", d_rdata, exp_d);
    drive();
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("done_single_pulse", if_done | d_done, 0);
  endtask

  initial begin
    reset = 1'b1;
    f_pend = 1'b0; d_pend = 1'b0; d_we_v = 1'b0;
    f_addr = '0; d_addr_v = '0; d_wd = '0;
    exp_if = '0; exp_d = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // Single fetch from 0x2000.
    mem[32'h2000]     = 64'hDEAD_BEEF_8C40_0000;
    ref_mem[32'h2000] = 64'hDEAD_BEEF_8C40_0000;
    f_pend = 1'b1; f_addr = 32'h2000;
    round();

    // Store.
    d_pend = 1'b1; d_we_v = 1'b1; d_addr_v = 32'h0007_FFF8; d_wd = 64'h1122_3344_5566_7788;
    round();

    // Simultaneous load and fetch: data first, then fetch.
    d_pend = 1'b1; d_we_v = 1'b0; d_addr_v = 32'h0007_FFF8;
    f_pend = 1'b1; f_addr = 32'h2000;
    round();
    round();

    // Fetch held while data keeps re-presenting: starvation bound.
    new_fetch();
    repeat (10) begin
      if (!f_pend) new_fetch();
      if (!d_pend) new_data();
      round();
    end
    f_pend = 1'b0;
    if (d_pend) round();

    // Reset during WAIT of a load.
    d_pend = 1'b1; d_we_v = 1'b0; d_addr_v = 32'h1008;
    drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero("rst_wait");
    reset = 1'b0;
    d_pend = 1'b0; exp_if = '0; exp_d = '0; starve = 0;
    f_pend = 1'b1; f_addr = 32'h2000;
    round();

    // Random rounds.
    repeat (40) begin
      if (!f_pend && $urandom_range(0, 1) == 1) new_fetch();
      if (!d_pend && $urandom_range(0, 2) != 0) new_data();
      if (!f_pend && !d_pend) new_data();
      round();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
